// File: rtl/combo_lock_n.sv
// Parametrised keypad combination lock: synchronises the raw key strobe,
// accepts one key event per press, checks an N-symbol code with programming and lockout.
module combo_lock_n #(
  parameter int unsigned               CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]     DEFAULT_CODE   = 16'h123A,
  parameter int unsigned               MAX_FAIL       = 3,
  parameter int unsigned               LOCKOUT_CYCLES = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_validn,
  input  logic [3:0]                         key_code,
  output logic [4*CODE_LEN-1:0]              entered,
  output logic [$clog2(CODE_LEN+1)-1:0]      count,
  output logic                               unlocked,
  output logic                               prog_mode,
  output logic                               lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

  localparam int unsigned W  = 4 * CODE_LEN;
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [CW-1:0] FULL       = CW'(CODE_LEN);
  localparam logic [FW-1:0] LIMIT      = FW'(MAX_FAIL);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

  localparam logic [3:0] KEY_PROG  = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic          validn_s1_q, validn_s1_d;
  logic          validn_s2_q, validn_s2_d;
  logic          prev_q, prev_d;
  logic          arm_q, arm_d;
  logic [3:0]    code_s1_q, code_s1_d;
  logic [3:0]    code_s2_q, code_s2_d;
  logic [W-1:0]  code_q, code_d;
  logic [W-1:0]  entered_q, entered_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          key_evt;
  logic          is_sym;
  logic [W-1:0]  entered_app;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOCKED;
      validn_s1_q <= 1'b1;
      validn_s2_q <= 1'b1;
      prev_q      <= 1'b1;
      arm_q       <= 1'b0;
      code_s1_q   <= '0;
      code_s2_q   <= '0;
      code_q      <= DEFAULT_CODE;
      entered_q   <= '0;
      count_q     <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      validn_s1_q <= validn_s1_d;
      validn_s2_q <= validn_s2_d;
      prev_q      <= prev_d;
      arm_q       <= arm_d;
      code_s1_q   <= code_s1_d;
      code_s2_q   <= code_s2_d;
      code_q      <= code_d;
      entered_q   <= entered_d;
      count_q     <= count_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    validn_s1_d = key_validn;
    validn_s2_d = validn_s1_q;
    code_s1_d   = key_code;
    code_s2_d   = code_s1_q;
    prev_d      = validn_s2_q;
    // Presses first seen during lockout never arm, so a key held across the exit is dropped.
    arm_d       = prev_q & ~validn_s2_q & (state_q != ST_LOCKOUT);

    key_evt     = arm_q & ~validn_s2_q;
    is_sym      = (code_s2_q <= 4'hC);
    entered_app = (entered_q << 4) | W'(code_s2_q);

    state_d   = state_q;
    code_d    = code_q;
    entered_d = entered_q;
    count_d   = count_q;
    fail_d    = fail_q;
    timer_d   = timer_q;

    case (state_q)
      ST_LOCKED: begin
        if (key_evt) begin
          if (is_sym) begin
            if (count_q != FULL) begin
              entered_d = entered_app;
              count_d   = count_q + 1'b1;
            end
          end else if (code_s2_q == KEY_CLEAR) begin
            entered_d = '0;
            count_d   = '0;
          end else if (code_s2_q == KEY_ENTER) begin
            entered_d = '0;
            count_d   = '0;
            if ((count_q == FULL) && (entered_q == code_q)) begin
              state_d = ST_OPEN;
              fail_d  = '0;
            end else if (fail_q + 1'b1 >= LIMIT) begin
              fail_d  = LIMIT;
              state_d = ST_LOCKOUT;
              timer_d = TIMER_LOAD;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end

      ST_OPEN: begin
        if (key_evt) begin
          if (code_s2_q == KEY_ENTER) begin
            state_d   = ST_LOCKED;
            entered_d = '0;
            count_d   = '0;
          end else if (code_s2_q == KEY_PROG) begin
            state_d   = ST_PROG;
            entered_d = '0;
            count_d   = '0;
          end
        end
      end

      ST_PROG: begin
        if (key_evt) begin
          if (is_sym) begin
            if (count_q != FULL) begin
              entered_d = entered_app;
              count_d   = count_q + 1'b1;
            end
          end else if (code_s2_q == KEY_CLEAR) begin
            entered_d = '0;
            count_d   = '0;
          end else if (code_s2_q == KEY_ENTER) begin
            if (count_q == FULL) begin
              code_d    = entered_q;
              entered_d = '0;
              count_d   = '0;
              state_d   = ST_OPEN;
            end
          end else begin
            entered_d = '0;
            count_d   = '0;
            state_d   = ST_OPEN;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = ST_LOCKED;
    endcase
  end

  assign entered   = entered_q;
  assign count     = count_q;
  assign unlocked  = (state_q == ST_OPEN);
  assign prog_mode = (state_q == ST_PROG);
  assign lockout   = (state_q == ST_LOCKOUT);
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_combo_lock_n.sv
// Bench for combo_lock_n: directed test-plan steps then random key traffic,
// checked against a key-event level model of the lock.
module tb_combo_lock_n;

  localparam int CL = 4;
  localparam int MF = 3;
  localparam int LC = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            key_validn;
  logic [3:0]      key_code;
  logic [4*CL-1:0] entered;
  logic [2:0]      count;
  logic            unlocked;
  logic            prog_mode;
  logic            lockout;
  logic [1:0]      fail_cnt;

  combo_lock_n #(
    .CODE_LEN(CL),
    .DEFAULT_CODE(16'h123A),
    .MAX_FAIL(MF),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_validn(key_validn),
    .key_code(key_code),
    .entered(entered),
    .count(count),
    .unlocked(unlocked),
    .prog_mode(prog_mode),
    .lockout(lockout),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: typed symbols and stored code as lists of nibbles.
  logic [3:0]  m_entry[$];
  logic [3:0]  m_code[$];
  bit          m_open, m_prog, m_in_lockout;
  int          m_fail;
  int unsigned m_lock_until;
  int unsigned last_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_entry();
    logic [31:0] v = '0;
    foreach (m_entry[i]) v = (v << 4) | 32'(m_entry[i]);
    return v;
  endfunction

  function automatic bit entry_matches();
    if (m_entry.size() != m_code.size()) return 1'b0;
    foreach (m_entry[i]) if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_entry.delete();
    m_code = '{4'h1, 4'h2, 4'h3, 4'hA};
    m_open = 0; m_prog = 0; m_in_lockout = 0; m_fail = 0; m_lock_until = 0;
  endtask

  task automatic model_sync();
    if (m_in_lockout && cyc >= m_lock_until) begin
      m_in_lockout = 0;
      m_fail = 0;
    end
  endtask

  // One accepted key event whose press began at edge count 'fall'.
  task automatic model_key(input logic [3:0] k, input int unsigned fall);
    if (m_in_lockout && fall < m_lock_until) return;
    if (m_in_lockout) begin m_in_lockout = 0; m_fail = 0; end
    if (m_open) begin
      if (k == 4'hE) begin m_open = 0; m_entry.delete(); end
      else if (k == 4'hD) begin m_open = 0; m_prog = 1; m_entry.delete(); end
    end else if (m_prog) begin
      if (k <= 4'hC) begin if (m_entry.size() < CL) m_entry.push_back(k); end
      else if (k == 4'hF) m_entry.delete();
      else if (k == 4'hE) begin
        if (m_entry.size() == CL) begin
          m_code = m_entry; m_entry.delete(); m_prog = 0; m_open = 1;
        end
      end else begin m_entry.delete(); m_prog = 0; m_open = 1; end
    end else begin
      if (k <= 4'hC) begin if (m_entry.size() < CL) m_entry.push_back(k); end
      else if (k == 4'hF) m_entry.delete();
      else if (k == 4'hE) begin
        if (entry_matches()) begin m_open = 1; m_fail = 0; end
        else begin
          m_fail++;
          if (m_fail >= MF) begin
            m_fail = MF;
            m_in_lockout = 1;
            m_lock_until = fall + 4 + LC;
          end
        end
        m_entry.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    model_sync();
    check({tag, ".entered"},  32'(entered),   pack_entry());
    check({tag, ".count"},    32'(count),     32'(m_entry.size()));
    check({tag, ".unlocked"}, 32'(unlocked),  32'(m_open));
    check({tag, ".prog"},     32'(prog_mode), 32'(m_prog));
    check({tag, ".lockout"},  32'(lockout),   32'(m_in_lockout));
    check({tag, ".fail"},     32'(fail_cnt),  32'(m_fail));
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    @(negedge clk);
    // Keep press starts clear of the lockout exit boundary.
    while (m_in_lockout && cyc + 8 > m_lock_until && cyc < m_lock_until + 2) @(negedge clk);
    last_fall  = cyc;
    key_code   = k;
    key_validn = 1'b0;
    repeat (hold) @(negedge clk);
    key_validn = 1'b1;
    key_code   = 4'($urandom);
    repeat (gap) @(negedge clk);
    if (hold >= 2) model_key(k, last_fall);
  endtask

  task automatic type_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--)
      press(4'(w >> (4 * i)), $urandom_range(2, 6), $urandom_range(4, 8));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_validn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned c;
    rst = 1'b1;
    key_validn = 1'b1;
    key_code = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");

    type_word(32'h123AE, 5);
    check_all("default_unlock");
    check("default_unlock.const", 32'(unlocked), 32'd1);
    press(4'hE, 3, 5);
    check_all("relock");

    type_word(32'h123BE, 5);
    check_all("wrong1");
    type_word(32'h123BE, 5);
    check_all("wrong2");
    type_word(32'h123BE, 5);
    check_all("wrong3");
    c = last_fall + 4;
    type_word(32'h56F, 3);
    check_all("lockout_keys");
    while (cyc < c + 80) @(negedge clk);
    key_code = 4'h7;
    key_validn = 1'b0;
    while (cyc < c + LC - 1) @(negedge clk);
    check("lockout_last_cycle", 32'(lockout), 32'd1);
    @(negedge clk);
    check("lockout_exit", 32'(lockout), 32'd0);
    check("lockout_exit.fail", 32'(fail_cnt), 32'd0);
    repeat (20) @(negedge clk);
    key_validn = 1'b1;
    repeat (6) @(negedge clk);
    check_all("span_exit");

    type_word(32'h123AE, 5);
    press(4'hD, 3, 5);
    check_all("enter_prog");
    type_word(32'h9876E, 5);
    check_all("reprog_done");
    press(4'hE, 4, 5);
    check_all("reprog_relock");
    type_word(32'h9876E, 5);
    check_all("new_code_unlock");
    press(4'hE, 2, 5);
    type_word(32'h123AE, 5);
    check_all("old_code_fails");

    type_word(32'h12345, 5);
    check_all("append_full");
    check("append_full.const", 32'(entered), 32'h1234);
    press(4'hF, 3, 5);
    check_all("clear");
    type_word(32'h9876E, 5);
    type_word(32'hD45E, 4);
    check_all("prog_short_enter");
    check("prog_short_enter.const", 32'(count), 32'd2);
    press(4'hD, 3, 5);
    check_all("prog_abort");
    press(4'hE, 3, 5);

    @(negedge clk);
    last_fall = cyc;
    key_code = 4'h3;
    key_validn = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_edge3.count", 32'(count), 32'd0);
    @(negedge clk);
    check("hold_edge4.count", 32'(count), 32'd1);
    check("hold_edge4.entered", 32'(entered), 32'h3);
    repeat (996) @(negedge clk);
    key_validn = 1'b1;
    repeat (6) @(negedge clk);
    model_key(4'h3, last_fall);
    check_all("hold_1000");
    press(4'h5, 1, 6);
    check_all("glitch");
    press(4'hF, 3, 5);

    type_word(32'h123AE, 5);
    type_word(32'h123AE, 5);
    type_word(32'h123AE, 5);
    check_all("lockout_again");
    repeat (20) @(negedge clk);
    do_reset();
    check_all("reset_mid_lockout");
    type_word(32'h123AE, 5);
    check_all("unlock_after_reset");
    type_word(32'hD5555E, 6);
    check_all("reprog_5555");
    do_reset();
    check_all("reset_after_prog");
    type_word(32'h123AE, 5);
    check_all("default_restored");

    for (int it = 0; it < 40; it++) begin
      int sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        press(4'($urandom), $urandom_range(2, 7), $urandom_range(4, 8));
      end else if (sel <= 7) begin
        foreach (m_code[i]) press(m_code[i], $urandom_range(2, 5), $urandom_range(4, 7));
        press(4'hE, $urandom_range(2, 5), $urandom_range(4, 7));
      end else if (sel == 8) begin
        press(4'($urandom), 1, $urandom_range(4, 8));
      end else begin
        press(4'hE, $urandom_range(2, 5), $urandom_range(4, 7));
      end
      check_all("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/combo_lock_n.md
Name: combo_lock_n

Overview:
- Parametrised successor to the 4-digit keypad combo receiver.
- Consumes the asynchronous key_validn/key_code pair from the keyboard transmitter and checks an N-symbol code.
- Adds an explicit Enter key (#, code E), clear (*, code F), a reprogrammable code (D while open) and a failed-attempt lockout timer.
- Sits between the keyboard block and the HEX display formatter. It exports raw state; it does no segment encoding.

Parameters:
- CODE_LEN, 4: symbols per code, legal range 1..8.
- DEFAULT_CODE, 16'h123A: code loaded at reset; width 4*CODE_LEN; first symbol sits in the MS nibble.
- MAX_FAIL, 3: consecutive wrong Enters that trigger lockout; legal range ≥1.
- LOCKOUT_CYCLES, 50_000_000: lockout duration in clk cycles; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key_validn  in  1  asynchronous; low while a key is held.
- key_code  in  4  asynchronous; stable whenever key_validn is low.
- entered  out  4*CODE_LEN  symbols typed so far; newest symbol in nibble [3:0].
- count  out  $clog2(CODE_LEN+1)  number of valid symbols in entered.
- unlocked  out  1  high in state OPEN.
- prog_mode  out  1  high in state PROG.
- lockout  out  1  high in state LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.

Behaviour:
- Input synchronisation: key_validn and key_code each pass through a 2FF synchroniser (s1, s2).
- Press detection: prev <= validn_s2 every cycle. A press is detected on prev=1 and validn_s2=0, and arms a sample for the next cycle.
- Sampling: on the armed cycle, if validn_s2 is still 0, key_code_s2 is committed as one key event. Only one event is accepted per press; no new event until validn_s2 returns high.
- Latency: input fall captured at edge 1 (s1), edge 2 (s2), edge 3 (arm), edge 4 (commit). Outputs reflect the key after edge 4.
- Key classes:
  - Symbol: codes 0..C.
  - ENTER: E.
  - CLEAR: F.
  - PROG: D.
- Append rule: on a symbol, entered <= {entered[4*CODE_LEN-5:0], sym} and count++. If count==CODE_LEN, the symbol is ignored; there is no shift-out.
- Reset: state=LOCKED; code register <= DEFAULT_CODE; entered=0; count=0; fail_cnt=0; lockout timer=0. All outputs low/zero.
- Reset mid-operation has the same effect as reset at power-up. An in-progress lockout is aborted, and a programmed code reverts to DEFAULT_CODE.
- State LOCKED:
  - Symbol: append.
  - CLEAR: entered=0, count=0.
  - PROG: ignored.
  - ENTER with count==CODE_LEN and entered==code: go to OPEN; fail_cnt=0; entered and count cleared.
  - Any other ENTER (wrong code or short entry): entered and count cleared; fail_cnt++.
  - If the incremented fail_cnt==MAX_FAIL: go to LOCKOUT and load timer=LOCKOUT_CYCLES-1.
- State OPEN:
  - ENTER: go to LOCKED (relock); clear entry.
  - PROG: go to PROG; clear entry.
  - Symbols and CLEAR: ignored; entered stays 0.
- State PROG:
  - Symbol: append.
  - CLEAR: clear entry.
  - ENTER with count==CODE_LEN: code <= entered; clear entry; go to OPEN.
  - ENTER with count<CODE_LEN: ignored; entry retained.
  - PROG: abort to OPEN; clear entry; code unchanged.
- State LOCKOUT:
  - All key events are discarded, including presses that span the exit.
  - Timer decrements by 1 per cycle. On the cycle timer==0: go to LOCKED; fail_cnt=0.
  - A key still held at exit is not accepted; the user must release and press again.
- Simultaneous rst and key commit: rst wins.
- Code compare is full-width, 4*CODE_LEN bits.
- fail_cnt saturates at MAX_FAIL.
- Glitch filtering: a validn_s2 low pulse of exactly 1 cycle gets armed but is rejected at the sample (validn_s2=1), producing no event.
- Outputs: all outputs are registered; none is combinational from the inputs.

Test Plan:
- Default code: CODE_LEN=4, keys 1,2,3,A,E (# ) → unlocked=1 after the E commit; fail_cnt=0; entered=0; count=0.
- Wrong code and lockout: MAX_FAIL=3, LOCKOUT_CYCLES=100.
  - Enter 1,2,3,B,E three times → fail_cnt 1, then 2, then lockout=1.
  - Keys pressed during lockout: no change.
  - Exactly 100 cycles after entry, lockout=0 and fail_cnt=0.
- Reprogramming:
  - From OPEN: D, 9,8,7,6, E → back in OPEN.
  - E relocks.
  - 9,8,7,6,E → unlocked.
  - 1,2,3,A,E → fail_cnt=1.
- Entry editing:
  - 1,2,3,4,5 → count=4, entered=16'h1234 (5 ignored).
  - F → count=0.
  - In PROG, E with count=2 → ignored; count stays 2.
- Input timing:
  - Hold key_validn low for 1000 cycles → exactly one event, committed on the 4th edge after the fall.
  - A 1-cycle low glitch → no event.
- Reset:
  - Assert rst mid-lockout and after reprogramming → LOCKED, outputs zero, code=16'h123A.
  - 1,2,3,A,E then unlocks.
